// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite register slave.
// Response codes follow the AXI encoding.
package axi_lite_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

endpackage

// File: rtl/axi_hold_reg.sv
// One-entry valid+data holding register with load and clear.
// Load wins over clear; the slave never issues both in one cycle.
module axi_hold_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave front end driving a register file's write/read ports.
// Optional AXI_LITE_STRICT_DECODE_EN: out-of-range addresses get DECERR and no write.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned NumWords    = 64,
  parameter int unsigned AddrWidth   = 12,
  localparam int unsigned OffsetWidth = $clog2(NumWords)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AddrWidth-1:0]   s_awaddr,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [DataWidth-1:0]   s_wdata,
  input  logic [StrbWidth-1:0]   s_wstrb,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  output logic [1:0]             s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready,
  input  logic [AddrWidth-1:0]   s_araddr,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  output logic [DataWidth-1:0]   s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rvalid,
  input  logic                   s_rready,
  output logic [OffsetWidth-1:0] wa,
  output logic [DataWidth-1:0]   wd,
  output logic [StrbWidth-1:0]   we,
  output logic [OffsetWidth-1:0] ra,
  input  logic [DataWidth-1:0]   rd
);

  localparam int unsigned AwHoldWidth = OffsetWidth + 1;
  localparam int unsigned WHoldWidth  = StrbWidth + DataWidth;

  logic aw_err, ar_err;

`ifdef AXI_LITE_STRICT_DECODE_EN
  assign aw_err = (s_awaddr >> (OffsetWidth + 2)) != '0;
  assign ar_err = (s_araddr >> (OffsetWidth + 2)) != '0;
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  // Byte-lane bits (and upper bits when aliasing) never reach the decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_awaddr, s_araddr};

  // Write path: independent AW / W holding registers.
  logic                   aw_held, w_held;
  logic [AwHoldWidth-1:0] aw_hold_q;
  logic [WHoldWidth-1:0]  w_hold_q;
  logic                   aw_load, w_load, commit;
  logic                   aw_err_h;
  logic [OffsetWidth-1:0] aw_off_h;
  logic [StrbWidth-1:0]   w_strb_h;
  logic [DataWidth-1:0]   w_data_h;

  logic  bvalid_q, bvalid_d;
  resp_t bresp_q, bresp_d;

  assign s_awready = ~aw_held & ~bvalid_q;
  assign s_wready  = ~w_held & ~bvalid_q;
  assign aw_load   = s_awvalid & s_awready;
  assign w_load    = s_wvalid & s_wready;
  // Gated by reset so a pending pair never reaches the array mid-reset.
  assign commit    = aw_held & w_held & ~bvalid_q & ~reset;

  axi_hold_reg #(
    .Width(AwHoldWidth)
  ) u_aw_hold (
    .clk    (clk),
    .reset  (reset),
    .load_i (aw_load),
    .clear_i(commit),
    .data_i ({aw_err, s_awaddr[OffsetWidth+1:2]}),
    .valid_o(aw_held),
    .data_o (aw_hold_q)
  );

  axi_hold_reg #(
    .Width(WHoldWidth)
  ) u_w_hold (
    .clk    (clk),
    .reset  (reset),
    .load_i (w_load),
    .clear_i(commit),
    .data_i ({s_wstrb, s_wdata}),
    .valid_o(w_held),
    .data_o (w_hold_q)
  );

  assign {aw_err_h, aw_off_h} = aw_hold_q;
  assign {w_strb_h, w_data_h} = w_hold_q;

  assign wa = aw_off_h;
  assign wd = w_data_h;
  assign we = (commit && !aw_err_h) ? w_strb_h : '0;

  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = aw_err_h ? DECERR : OKAY;
    end else if (bvalid_q && s_bready) begin
      bvalid_d = 1'b0;
    end
  end

  // Read path: single-cycle, held until R handshake.
  logic                 rvalid_q, rvalid_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  resp_t                rresp_q, rresp_d;
  logic                 ar_hs;

  assign s_arready = ~rvalid_q;
  assign ar_hs     = s_arvalid & s_arready;
  assign ra        = s_araddr[OffsetWidth+1:2];

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_err ? '0 : rd;
      rresp_d  = ar_err ? DECERR : OKAY;
    end else if (rvalid_q && s_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else begin
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign s_bvalid = bvalid_q;
  assign s_bresp  = bresp_q;
  assign s_rvalid = rvalid_q;
  assign s_rdata  = rdata_q;
  assign s_rresp  = rresp_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave with an attached register-file array.
// Expectations come from a word-array model of the AXI-visible register map.
module tb_axi_lite_reg_slave;

  localparam int NW = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b1;
  logic [11:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b1;
  logic [5:0]  wa;
  logic [31:0] wd;
  logic [3:0]  we;
  logic [5:0]  ra;
  logic [31:0] rd;

  axi_lite_reg_slave #(
    .NumWords (NW),
    .AddrWidth(12)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_awaddr (s_awaddr),
    .s_awvalid(s_awvalid),
    .s_awready(s_awready),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_wvalid (s_wvalid),
    .s_wready (s_wready),
    .s_bresp  (s_bresp),
    .s_bvalid (s_bvalid),
    .s_bready (s_bready),
    .s_araddr (s_araddr),
    .s_arvalid(s_arvalid),
    .s_arready(s_arready),
    .s_rdata  (s_rdata),
    .s_rresp  (s_rresp),
    .s_rvalid (s_rvalid),
    .s_rready (s_rready),
    .wa       (wa),
    .wd       (wd),
    .we       (we),
    .ra       (ra),
    .rd       (rd)
  );

  always #5 clk = ~clk;

  // Register file sitting downstream of the slave.
  logic [31:0] rf [NW];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NW; i++) rf[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) if (we[b]) rf[wa][8*b +: 8] <= wd[8*b +: 8];
    end
  end
  assign rd = rf[ra];

  int we_cnt = 0;
  always @(negedge clk) if (we != 4'h0) we_cnt <= we_cnt + 1;

  int vecs = 0;
  int errs = 0;
  logic [31:0] exp_mem [NW];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [11:0] a);
`ifdef AXI_LITE_STRICT_DECODE_EN
    return int'(a) < NW * 4;
`else
    return a == a;
`endif
  endfunction

  function automatic int offs(input logic [11:0] a);
    return (int'(a) / 4) % NW;
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [11:0] a);
    return in_rng(a) ? exp_mem[offs(a)] : 32'h0;
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_rng(a))
      for (int b = 0; b < 4; b++) if (s[b]) exp_mem[offs(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < NW; i++) exp_mem[i] = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [11:0] a);
    s_awaddr  = a;
    s_awvalid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (s_awready) begin
        tick();
        s_awvalid = 1'b0;
        return;
      end
      tick();
    end
    s_awvalid = 1'b0;
    chk("aw_timeout", 32'(s_awready), 32'd1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    s_wdata  = d;
    s_wstrb  = s;
    s_wvalid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (s_wready) begin
        tick();
        s_wvalid = 1'b0;
        return;
      end
      tick();
    end
    s_wvalid = 1'b0;
    chk("w_timeout", 32'(s_wready), 32'd1);
  endtask

  // order: 0 = AW and W together, 1 = W leads by gap cycles, 2 = AW leads by gap cycles.
  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int order, input int gap,
                          input logic [3:0] exp_we, input logic [5:0] exp_wa);
    int cnt0;
    cnt0 = we_cnt;
    fork
      begin
        if (order == 2) repeat (gap) tick();
        send_w(d, s);
      end
      begin
        if (order == 1) repeat (gap) tick();
        send_aw(a);
      end
    join
    chk("awready_held", 32'(s_awready), 32'd0);
    chk("wready_held", 32'(s_wready), 32'd0);
    chk("commit_we", 32'(we), 32'(exp_we));
    if (exp_we != 4'h0) begin
      chk("commit_wa", 32'(wa), 32'(exp_wa));
      chk("commit_wd", wd, d);
    end
    chk("bvalid_early", 32'(s_bvalid), 32'd0);
    tick();
    chk("bvalid", 32'(s_bvalid), 32'd1);
    chk("bresp", 32'(s_bresp), in_rng(a) ? 32'd0 : 32'd3);
    chk("we_after_commit", 32'(we), 32'd0);
    chk("we_pulses", 32'(we_cnt - cnt0), (exp_we != 4'h0) ? 32'd1 : 32'd0);
    model_write(a, d, s);
    if (s_bready) begin
      tick();
      chk("bvalid_drop", 32'(s_bvalid), 32'd0);
    end
  endtask

  task automatic do_read(input logic [11:0] a, input string nm);
    logic [31:0] ed;
    bit          got;
    ed        = mdl_rd(a);
    got       = 1'b0;
    s_araddr  = a;
    s_arvalid = 1'b1;
    #1;
    chk({nm, "_ra"}, 32'(ra), 32'(offs(a)));
    for (int i = 0; i < 64 && !got; i++) begin
      if (s_arready) got = 1'b1;
      tick();
    end
    s_arvalid = 1'b0;
    chk({nm, "_rvalid"}, 32'(s_rvalid), 32'd1);
    chk({nm, "_rdata"}, s_rdata, ed);
    chk({nm, "_rresp"}, 32'(s_rresp), in_rng(a) ? 32'd0 : 32'd3);
    if (s_rready) begin
      tick();
      chk({nm, "_rvalid_drop"}, 32'(s_rvalid), 32'd0);
    end
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          order;
    int          gap;
    logic [3:0]  exp_we;
    logic [5:0]  exp_wa;
  } wvec_t;

  wvec_t       tbl [6];
  int          cnt0;
  logic [31:0] held;
  logic [11:0] ra_addr;
  logic [31:0] rnd_d;
  logic [3:0]  rnd_s;

  initial begin
    tbl[0] = '{12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 4'hF, 6'd4};
    tbl[1] = '{12'h020, 32'h11223344, 4'b0101, 1, 3, 4'b0101, 6'd8};
    tbl[2] = '{12'h004, 32'h13579BDF, 4'hF, 2, 1, 4'hF, 6'd1};
    tbl[3] = '{12'h07C, 32'hA5A5A5A5, 4'b1000, 2, 2, 4'b1000, 6'd31};
    tbl[4] = '{12'h0FE, 32'h01234567, 4'b0011, 0, 0, 4'b0011, 6'd63};
`ifdef AXI_LITE_STRICT_DECODE_EN
    tbl[5] = '{12'h400, 32'h55AA55AA, 4'hF, 0, 0, 4'h0, 6'd0};
`else
    tbl[5] = '{12'h400, 32'h55AA55AA, 4'hF, 0, 0, 4'hF, 6'd0};
`endif

    model_clear();
    repeat (2) tick();
    chk("we_in_reset", 32'(we), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_awready", 32'(s_awready), 32'd1);
    chk("rst_wready", 32'(s_wready), 32'd1);
    chk("rst_arready", 32'(s_arready), 32'd1);
    chk("rst_bvalid", 32'(s_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    chk("rst_resp", {28'd0, s_bresp, s_rresp}, 32'd0);
    chk("rst_we", 32'(we), 32'd0);

    for (int i = 0; i < 6; i++)
      do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].order, tbl[i].gap,
               tbl[i].exp_we, tbl[i].exp_wa);
    do_read(12'h010, "rd_010");
    chk("rd_010_value", s_rdata, 32'hDEADBEEF);
    do_read(12'h020, "rd_020");
    chk("rd_020_value", s_rdata, 32'h00220044);
    do_read(12'h000, "rd_000");
    do_read(12'h0FC, "rd_0fc");

    // B channel back-pressure with a second write waiting.
    s_bready = 1'b0;
    do_write(12'h040, 32'h0F0F0F0F, 4'hF, 0, 0, 4'hF, 6'd16);
    cnt0      = we_cnt;
    s_awaddr  = 12'h044;
    s_awvalid = 1'b1;
    s_wdata   = 32'h0BADF00D;
    s_wstrb   = 4'hF;
    s_wvalid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bstall_bvalid", 32'(s_bvalid), 32'd1);
      chk("bstall_ready", {30'd0, s_awready, s_wready}, 32'd0);
      tick();
    end
    chk("bstall_no_we", 32'(we_cnt - cnt0), 32'd0);
    s_bready = 1'b1;
    tick();
    chk("bstall_released", {30'd0, s_bvalid, s_awready}, 32'd1);
    tick();
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    chk("bstall_next_we", 32'(we), 32'hF);
    chk("bstall_next_wa", 32'(wa), 32'd17);
    chk("bstall_next_wd", wd, 32'h0BADF00D);
    model_write(12'h044, 32'h0BADF00D, 4'hF);
    tick();
    chk("bstall_next_bvalid", 32'(s_bvalid), 32'd1);
    tick();
    chk("bstall_next_bdrop", 32'(s_bvalid), 32'd0);

    // R channel back-pressure with a second read waiting.
    s_rready  = 1'b0;
    s_araddr  = 12'h004;
    s_arvalid = 1'b1;
    tick();
    s_araddr = 12'h010;
    held     = exp_mem[1];
    for (int i = 0; i < 4; i++) begin
      chk("rstall_rvalid", 32'(s_rvalid), 32'd1);
      chk("rstall_rdata", s_rdata, held);
      chk("rstall_arready", 32'(s_arready), 32'd0);
      tick();
    end
    s_rready = 1'b1;
    tick();
    chk("rstall_drop", {30'd0, s_rvalid, s_arready}, 32'd1);
    tick();
    s_arvalid = 1'b0;
    chk("rstall_next_rvalid", 32'(s_rvalid), 32'd1);
    chk("rstall_next_rdata", s_rdata, mdl_rd(12'h010));
    tick();

    // Read in the commit cycle returns the pre-write value.
    do_write(12'h030, 32'h00001111, 4'hF, 0, 0, 4'hF, 6'd12);
    s_awaddr  = 12'h030;
    s_awvalid = 1'b1;
    s_wdata   = 32'hCAFEF00D;
    s_wstrb   = 4'hF;
    s_wvalid  = 1'b1;
    tick();
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_araddr  = 12'h030;
    s_arvalid = 1'b1;
    chk("coll_we", 32'(we), 32'hF);
    tick();
    s_arvalid = 1'b0;
    chk("coll_rvalid", 32'(s_rvalid), 32'd1);
    chk("coll_old", s_rdata, 32'h00001111);
    chk("coll_bvalid", 32'(s_bvalid), 32'd1);
    model_write(12'h030, 32'hCAFEF00D, 4'hF);
    tick();
    do_read(12'h030, "coll_after");
    chk("coll_new", s_rdata, 32'hCAFEF00D);

    // Reset between AW and W acceptance.
    send_aw(12'h014);
    reset = 1'b1;
    #1;
    chk("midrst_we", 32'(we), 32'd0);
    tick();
    reset = 1'b0;
    model_clear();
    cnt0 = we_cnt;
    chk("midrst_state", {29'd0, s_bvalid, s_awready, s_wready}, 32'd3);
    send_w(32'h77777777, 4'hF);
    repeat (2) tick();
    chk("midrst_no_commit", 32'(we_cnt - cnt0), 32'd0);
    chk("midrst_bvalid", 32'(s_bvalid), 32'd0);
    send_aw(12'h018);
    chk("midrst_we2", 32'(we), 32'hF);
    chk("midrst_wa2", 32'(wa), 32'd6);
    chk("midrst_wd2", wd, 32'h77777777);
    model_write(12'h018, 32'h77777777, 4'hF);
    tick();
    chk("midrst_bvalid2", 32'(s_bvalid), 32'd1);
    tick();
    do_read(12'h014, "midrst_rd014");
    do_read(12'h018, "midrst_rd018");

    // Randomised traffic against the model.
    for (int i = 0; i < 60; i++) begin
      ra_addr = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) != 0) ra_addr[11:8] = 4'h0;
      if ($urandom_range(0, 2) == 0) begin
        do_read(ra_addr, "rnd_rd");
      end else begin
        rnd_d = $urandom();
        rnd_s = 4'($urandom_range(0, 15));
        do_write(ra_addr, rnd_d, rnd_s, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                 in_rng(ra_addr) ? rnd_s : 4'h0, 6'(ra_addr >> 2));
      end
    end
    for (int i = 0; i < NW; i += 7) do_read(12'(i * 4), "final_rd");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
AXI4-Lite slave front end that converts AW/W/B and AR/R transactions into reg_file port accesses (wa/wd/we, ra/rd). Sits directly upstream of the register file, between the interconnect and the storage array. Byte addresses are decoded to word offsets. Write strobes pass straight through to the byte-lane write enables.

Parameters:
NumWords, 64, number of 32-bit registers; must be a power of two.
AddrWidth, 12, AXI byte-address width; must be ≥ OffsetWidth+2.
OffsetWidth, $clog2(NumWords), localparam; width of the word offset.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_awaddr  in  AddrWidth  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  32  write data
s_wstrb  in  4  write byte strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  AddrWidth  read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rvalid  out  1  read response valid
s_rready  in  1  read response ready
wa  out  OffsetWidth  reg_file write offset
wd  out  32  reg_file write data
we  out  4  reg_file byte write enables
ra  out  OffsetWidth  reg_file read offset
rd  in  32  reg_file read data (combinational from ra)

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: all valids 0; aw_held=0, w_held=0; bresp=rresp=0; rdata=0; we=0. The ready outputs follow their equations, so they are 1 after reset.
- Offset decode: offset = addr[OffsetWidth+1:2]. addr[1:0] is ignored; no unaligned error.
- AW and W are accepted independently into holding registers.
  - s_awready = ~aw_held & ~s_bvalid.
  - s_wready = ~w_held & ~s_bvalid.
- Write commit happens in the cycle where aw_held & w_held & ~s_bvalid.
  - we = held wstrb (masked, see Optional Feature); wa and wd come from the holding registers.
  - At that edge: s_bvalid<=1, holds cleared, s_bresp set.
  - we is 0 in every other cycle.
- Write latency: AW and W accepted at edge t → commit cycle t+1 → s_bvalid high from edge t+2. AW and W may arrive in either order, any number of cycles apart.
- B channel: s_bvalid holds until s_bready. No new AW/W is accepted while s_bvalid=1, so at most one write is outstanding.
- Read channel:
  - s_arready = ~s_rvalid.
  - ra = s_araddr offset, combinational.
  - On AR handshake: s_rdata<=rd, s_rresp set, s_rvalid<=1. Read latency is one cycle.
  - s_rvalid and s_rdata hold stable until s_rready.
- Simultaneous read and commit-write to the same offset in one cycle: the read returns the pre-write value. There is no bypass.
- The read and write paths are fully independent and may proceed in the same cycle.
- Reset mid-transaction drops all held and pending state. There is no partial write: we is 0 during reset.

Optional Feature:
Macro: AXI_LITE_STRICT_DECODE_EN.
- Defined:
  - Any address with addr[AddrWidth-1:OffsetWidth+2] ≠ 0 is out of range.
  - Out-of-range write: commit cycle still occurs, but we=0; s_bresp=DECERR (2'b11).
  - Out-of-range read: s_rdata=0, s_rresp=DECERR.
- Undefined:
  - Upper address bits are ignored; addresses alias modulo NumWords*4.
  - Responses are always OKAY (2'b00).

Decomposition:
- Package axi_lite_pkg:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - Constant DataWidth=32.
  - Constant StrbWidth=4.
- Sub-module axi_hold_reg, parameterised by width: a one-entry valid+data holding register with load/clear. It is instantiated for AW (addr) and for W (data+strb).

Test Plan:
- AW 0x010 and W 0xDEADBEEF, strb 4'hF, in the same cycle, bready=1 → s_awready/s_wready low from the next cycle; we=4'hF, wa=4, wd=0xDEADBEEF one cycle after acceptance; bvalid two cycles after acceptance, bresp=OKAY. Then AR 0x010 → rvalid next cycle, rdata=0xDEADBEEF.
- W 0x11223344 strb 4'b0101 sent 3 cycles before AW 0x020 → exactly one commit cycle with we=4'b0101, wa=8, wd=0x11223344; a later read of 0x020 returns 0x00220044 (register cleared at reset).
- bready held low 5 cycles after a write → bvalid stays 1, awready=wready=0 for 5 cycles, no second we pulse; normal acceptance resumes after the B handshake.
- rready low 4 cycles after AR 0x004 → rvalid and rdata stable, arready=0; a new AR is accepted only after the R handshake.
- Read of 0x030 issued in the commit cycle of a write to 0x030 (0xCAFEF00D) → returns the old value; the next read returns 0xCAFEF00D.
- With AXI_LITE_STRICT_DECODE_EN, write to 0x400 (NumWords=64) → we stays 0, bresp=DECERR. Without the macro, the same write hits offset 0 with bresp=OKAY.
- reset asserted for one cycle after AW is accepted but before W → no commit; bvalid=0; the next full write behaves normally.
